// File: rtl/emu_ram_scan_pkg.sv
// Shared helpers for the scannable emulation RAM: chunk/total/counter sizing,
// read-during-write mode constants and the scan session state type.
// Ports: none (package).
package emu_ram_scan_pkg;

  localparam int RDW_OLD = 0;  // same-address read during write returns old data
  localparam int RDW_NEW = 1;  // same-address read during write returns wdata

  typedef enum logic [1:0] {
    SCAN_IDLE   = 2'd0,
    SCAN_ACTIVE = 2'd1,
    SCAN_DONE   = 2'd2
  } scan_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int calc_chunks(input int dw, input int sw);
    return ceil_div(dw, sw);
  endfunction

  function automatic int calc_total(input int depth, input int dw, input int sw);
    return depth * calc_chunks(dw, sw);
  endfunction

  function automatic int calc_cnt_w(input int depth, input int dw, input int sw);
    return $clog2(calc_total(depth, dw, sw) + 1);
  endfunction

endpackage

// File: rtl/emu_ram_mrsw_scan_if.sv
// Bus bundle for the scannable emulation RAM: functional write/read ports
// plus the RAM scan chain. master = driver (EMU_DUT / checkpoint controller),
// slave = the memory model. Read data and dump data flow slave -> master.
interface emu_ram_mrsw_scan_if #(
  parameter int DATA_WIDTH = 80,
  parameter int DEPTH      = 8,
  parameter int NRD        = 2,
  parameter int SCAN_WIDTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic                      dut_en;
  logic                      wen;
  logic [AW-1:0]             waddr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [NRD*AW-1:0]         raddr;
  logic [NRD*DATA_WIDTH-1:0] rdata;
  logic                      ram_se;
  logic                      ram_sd;
  logic [SCAN_WIDTH-1:0]     ram_di;
  logic [SCAN_WIDTH-1:0]     ram_do;
  logic                      ram_done;

  modport master (
    output dut_en, wen, waddr, wdata, raddr, ram_se, ram_sd, ram_di,
    input  rdata, ram_do, ram_done
  );

  modport slave (
    input  dut_en, wen, waddr, wdata, raddr, ram_se, ram_sd, ram_di,
    output rdata, ram_do, ram_done
  );

endinterface

// File: rtl/emu_ram_scan_ctrl.sv
// Scan session controller: IDLE -> ACTIVE -> DONE, reset whenever se is low.
// Ports: clk/rst; se/sd scan enable/direction; word_idx/chunk_idx current
// chunk position; dump_fire/restore_fire per-chunk strobes; last_chunk marks
// the final chunk of a word; dump_vld qualifies the dump read register; done.
module emu_ram_scan_ctrl
  import emu_ram_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 80,
  parameter int DEPTH      = 8,
  parameter int SCAN_WIDTH = 64,
  localparam int AW        = $clog2(DEPTH),
  localparam int CHUNKS    = calc_chunks(DATA_WIDTH, SCAN_WIDTH),
  localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          se,
  input  logic          sd,
  output logic [AW-1:0] word_idx,
  output logic [CW-1:0] chunk_idx,
  output logic          dump_fire,
  output logic          restore_fire,
  output logic          last_chunk,
  output logic          dump_vld,
  output logic          done
);

  localparam int              TOTAL      = calc_total(DEPTH, DATA_WIDTH, SCAN_WIDTH);
  localparam int              CNTW       = calc_cnt_w(DEPTH, DATA_WIDTH, SCAN_WIDTH);
  localparam logic [CNTW-1:0] TOTAL_C    = CNTW'(TOTAL);
  localparam logic [CNTW-1:0] LAST_CNT   = CNTW'(TOTAL - 1);
  localparam logic [CW-1:0]   LAST_CHUNK = CW'(CHUNKS - 1);

  scan_state_t     state;
  logic [CNTW-1:0] cnt;
  logic            xfer;

  // One chunk moves every scan cycle until TOTAL have gone; cnt saturates at TOTAL.
  assign xfer         = se && !rst && (cnt != TOTAL_C);
  assign dump_fire    = xfer && !sd;
  assign restore_fire = xfer && sd;
  assign last_chunk   = (chunk_idx == LAST_CHUNK);

  always_ff @(posedge clk) begin
    if (rst || !se) begin
      state     <= SCAN_IDLE;
      cnt       <= '0;
      word_idx  <= '0;
      chunk_idx <= '0;
      dump_vld  <= 1'b0;
      done      <= 1'b0;
    end else begin
      dump_vld <= dump_fire;
      if (xfer) begin
        cnt <= cnt + 1'b1;
        if (last_chunk) begin
          chunk_idx <= '0;
          word_idx  <= word_idx + 1'b1;
        end else begin
          chunk_idx <= chunk_idx + 1'b1;
        end
      end
      case (state)
        SCAN_IDLE: state <= SCAN_ACTIVE;
        SCAN_ACTIVE: begin
          // Restore finishes as the last chunk is taken; dump finishes once
          // the last chunk has left ram_do (pipeline drained).
          if (sd ? (xfer && cnt == LAST_CNT) : (cnt == TOTAL_C && !dump_vld)) begin
            state <= SCAN_DONE;
            done  <= 1'b1;
          end
        end
        SCAN_DONE: state <= SCAN_DONE;
        default:   state <= SCAN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/emu_ram_mrsw_scan.sv
// Emulation memory model: DEPTH x DATA_WIDTH array, NRD registered read ports,
// one write port, full-array dump/restore over a SCAN_WIDTH-bit scan chain.
// Ports: clk, rst (sync, active high), bus (slave modport: functional + scan).
module emu_ram_mrsw_scan
  import emu_ram_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 80,
  parameter int DEPTH      = 8,
  parameter int NRD        = 2,
  parameter int SCAN_WIDTH = 64,
  parameter int RDW_MODE   = RDW_OLD
) (
  input logic                clk,
  input logic                rst,
  emu_ram_mrsw_scan_if.slave bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CHUNKS = calc_chunks(DATA_WIDTH, SCAN_WIDTH);
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PADW   = CHUNKS * SCAN_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         word_idx;
  logic [CW-1:0]         chunk_idx;
  logic                  dump_fire;
  logic                  restore_fire;
  logic                  last_chunk;
  logic                  dump_vld;
  logic                  scan_done;
  logic                  func_en;
  logic [PADW-1:0]       dump_word;
  logic [PADW-1:0]       asm_q;
  logic [PADW-1:0]       asm_next;
  logic [SCAN_WIDTH-1:0] dump_q;

  emu_ram_scan_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .SCAN_WIDTH (SCAN_WIDTH)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .se           (bus.ram_se),
    .sd           (bus.ram_sd),
    .word_idx     (word_idx),
    .chunk_idx    (chunk_idx),
    .dump_fire    (dump_fire),
    .restore_fire (restore_fire),
    .last_chunk   (last_chunk),
    .dump_vld     (dump_vld),
    .done         (scan_done)
  );

  // Scan owns the array whenever ram_se is high, regardless of dut_en.
  assign func_en = bus.dut_en && !bus.ram_se && !rst;

  // Zero-pad the word so the last chunk's unused upper bits dump as 0.
  always_comb begin
    dump_word = '0;
    dump_word[DATA_WIDTH-1:0] = mem[word_idx];
  end

  // Drop the incoming chunk into its slot; the word is written from this view.
  always_comb begin
    asm_next = asm_q;
    asm_next[chunk_idx*SCAN_WIDTH +: SCAN_WIDTH] = bus.ram_di;
  end

  always_ff @(posedge clk) begin
    if (restore_fire && last_chunk) begin
      mem[word_idx] <= asm_next[DATA_WIDTH-1:0];
    end else if (func_en && bus.wen) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.ram_se) begin
      asm_q <= '0;
    end else if (restore_fire) begin
      asm_q <= last_chunk ? '0 : asm_next;
    end
  end

  // Two-stage dump: array read register, then the ram_do register.
  always_ff @(posedge clk) begin
    if (dump_fire) begin
      dump_q <= dump_word[chunk_idx*SCAN_WIDTH +: SCAN_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ram_do <= '0;
    end else begin
      bus.ram_do <= dump_vld ? dump_q : '0;
    end
  end

  assign bus.ram_done = scan_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata <= '0;
    end else if (func_en) begin
      for (int k = 0; k < NRD; k++) begin
        if (RDW_MODE == RDW_NEW && bus.wen && bus.waddr == bus.raddr[k*AW +: AW]) begin
          bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] <= bus.wdata;
        end else begin
          bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] <= mem[bus.raddr[k*AW +: AW]];
        end
      end
    end
  end

endmodule
